// File: rtl/aes_pkg.sv
// aes_pkg: GF(2^8) helpers shared by the AES MixColumns datapath.
// Every multiply is built from xtime; reduction polynomial x^8+x^4+x^3+x+1.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t AES_REDUCE = 8'h1B;

  // Multiply by x (i.e. by 2) in GF(2^8) with conditional reduction.
  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_REDUCE : 8'h00);
  endfunction

  function automatic byte_t gf_mul2(input byte_t x);
    return xtime(x);
  endfunction

  function automatic byte_t gf_mul3(input byte_t x);
    return xtime(x) ^ x;
  endfunction

  // 8*x, the common term of the inverse-matrix constants.
  function automatic byte_t gf_mul8(input byte_t x);
    return xtime(xtime(xtime(x)));
  endfunction

  function automatic byte_t gf_mul9(input byte_t x);
    return gf_mul8(x) ^ x;
  endfunction

  function automatic byte_t gf_mulb(input byte_t x);
    return gf_mul8(x) ^ xtime(x) ^ x;
  endfunction

  function automatic byte_t gf_muld(input byte_t x);
    return gf_mul8(x) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic byte_t gf_mule(input byte_t x);
    return gf_mul8(x) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

endpackage : aes_pkg

// File: rtl/mix_single_column.sv
// mix_single_column: combinational MixColumns over one 32-bit state column.
// Byte s0 is bits [31:24], s3 is bits [7:0]; output uses the same layout.
// Optional macro INV_MIX_COLUMNS_EN builds the inverse matrix, selected by inv_i.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);

  byte_t s0, s1, s2, s3;
  byte_t f0, f1, f2, f3;

  assign s0 = col_i[31:24];
  assign s1 = col_i[23:16];
  assign s2 = col_i[15:8];
  assign s3 = col_i[7:0];

  // Forward matrix rows {2,3,1,1} rotated per output byte.
  always_comb begin
    f0 = gf_mul2(s0) ^ gf_mul3(s1) ^ s2          ^ s3;
    f1 = s0          ^ gf_mul2(s1) ^ gf_mul3(s2) ^ s3;
    f2 = s0          ^ s1          ^ gf_mul2(s2) ^ gf_mul3(s3);
    f3 = gf_mul3(s0) ^ s1          ^ s2          ^ gf_mul2(s3);
  end

`ifdef INV_MIX_COLUMNS_EN
  byte_t i0, i1, i2, i3;

  // Inverse matrix rows {E,B,D,9} rotated per output byte, then select by inv.
  always_comb begin
    i0 = gf_mule(s0) ^ gf_mulb(s1) ^ gf_muld(s2) ^ gf_mul9(s3);
    i1 = gf_mul9(s0) ^ gf_mule(s1) ^ gf_mulb(s2) ^ gf_muld(s3);
    i2 = gf_muld(s0) ^ gf_mul9(s1) ^ gf_mule(s2) ^ gf_mulb(s3);
    i3 = gf_mulb(s0) ^ gf_muld(s1) ^ gf_mul9(s2) ^ gf_mule(s3);
    if (inv_i) begin
      col_o = {i0, i1, i2, i3};
    end else begin
      col_o = {f0, f1, f2, f3};
    end
  end
`else
  // inv has no effect in the forward-only build; keep the port for a fixed interface.
  logic unused_inv_s;
  assign unused_inv_s = inv_i;

  // Forward-only build: the column result is always the forward transform.
  always_comb begin
    col_o = {f0, f1, f2, f3};
  end
`endif

endmodule : mix_single_column

// File: rtl/aes_mix_columns.sv
// aes_mix_columns: registered AES MixColumns applied lane-wise to a vector.
// One-cycle latency, one vector per cycle, no stall. Lanes never mix bytes.
// Optional macro INV_MIX_COLUMNS_EN enables InvMixColumns through the inv port.
module aes_mix_columns
  import aes_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_in,
  input  logic                              inv,
  input  logic [vecSize-1:0][regSize-1:0]   vect,
  output logic [vecSize-1:0][regSize-1:0]   new_vect,
  output logic                              valid_out
);

  if (regSize != 32) begin : g_bad_reg_size
    $error("aes_mix_columns: regSize must be 32");
  end
  if (vecSize < 1) begin : g_bad_vec_size
    $error("aes_mix_columns: vecSize must be at least 1");
  end

  logic [vecSize-1:0][regSize-1:0] mixed_s;
  logic [vecSize-1:0][regSize-1:0] new_vect_d, new_vect_q;
  logic                            valid_out_d, valid_out_q;

  for (genvar g = 0; g < vecSize; g++) begin : g_lane
    mix_single_column u_col (
      .col_i (vect[g]),
      .inv_i (inv),
      .col_o (mixed_s[g])
    );
  end

  // Capture the transformed vector when valid; otherwise hold data and drop valid.
  always_comb begin
    new_vect_d  = new_vect_q;
    valid_out_d = 1'b0;
    if (valid_in) begin
      new_vect_d  = mixed_s;
      valid_out_d = 1'b1;
    end else begin
      new_vect_d  = new_vect_q;
      valid_out_d = 1'b0;
    end
  end

  // Result and valid registers; reset clears both immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_vect_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      new_vect_q  <= new_vect_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign new_vect  = new_vect_q;
  assign valid_out = valid_out_q;

endmodule : aes_mix_columns

// File: tb/tb_aes_mix_columns.sv
// tb_aes_mix_columns: table-driven and random checks of aes_mix_columns at
// vecSize 4 (main), 1 and 8, with a queue-based scoreboard per instance.
module tb_aes_mix_columns;

  logic                 clk;
  logic                 rst;
  logic                 valid_in;
  logic                 inv;
  logic [3:0][31:0]     vect4, nv4;
  logic [0:0][31:0]     vect1, nv1;
  logic [7:0][31:0]     vect8, nv8;
  logic                 vo4, vo1, vo8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] q4[$];
  logic [255:0] q1[$];
  logic [255:0] q8[$];
  logic [255:0] last4, last1, last8;

  aes_mix_columns #(.regSize(32), .vecSize(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .inv(inv),
    .vect(vect4), .new_vect(nv4), .valid_out(vo4));

  aes_mix_columns #(.regSize(32), .vecSize(1)) dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .inv(inv),
    .vect(vect1), .new_vect(nv1), .valid_out(vo1));

  aes_mix_columns #(.regSize(32), .vecSize(8)) dut8 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .inv(inv),
    .vect(vect8), .new_vect(nv8), .valid_out(vo8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: shift-and-add GF(2^8) multiply, circulant matrix per column.
  function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1B;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [31:0] mc(input logic [31:0] c, input logic iv);
    logic [7:0] m [4];
    logic [7:0] s [4];
    logic [7:0] r;
    logic [31:0] o;
    logic use_inv;
`ifdef INV_MIX_COLUMNS_EN
    use_inv = iv;
`else
    use_inv = 1'b0 & iv;
`endif
    if (use_inv) begin
      m[0] = 8'h0E; m[1] = 8'h0B; m[2] = 8'h0D; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    for (int j = 0; j < 4; j++) s[j] = c[31-8*j -: 8];
    o = 32'h0;
    for (int row = 0; row < 4; row++) begin
      r = 8'h00;
      for (int j = 0; j < 4; j++) r = r ^ gm(m[(j - row) & 3], s[j]);
      o[31-8*row -: 8] = r;
    end
    return o;
  endfunction

  function automatic logic [127:0] mc4(input logic [127:0] x, input logic iv);
    logic [127:0] o;
    for (int l = 0; l < 4; l++) o[32*l +: 32] = mc(x[32*l +: 32], iv);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive all instances, push model expectations, check at negedge.
  task automatic cycle(input logic v, input logic iv, input logic [127:0] x4,
                       input logic [127:0] e4, input string nm);
    logic [31:0]  x1;
    logic [255:0] x8, e8, e;
    x1 = $urandom;
    for (int l = 0; l < 8; l++) x8[32*l +: 32] = $urandom;
    e8 = '0;
    for (int l = 0; l < 8; l++) e8[32*l +: 32] = mc(x8[32*l +: 32], iv);
    valid_in = v;
    inv      = iv;
    vect4    = x4;
    vect1    = x1;
    vect8    = x8;
    if (v) begin
      q4.push_back({128'h0, e4});
      q1.push_back({224'h0, mc(x1, iv)});
      q8.push_back(e8);
    end
    @(posedge clk);
    @(negedge clk);
    chk({nm, "/valid4"}, {255'h0, vo4}, {255'h0, v});
    chk({nm, "/valid1"}, {255'h0, vo1}, {255'h0, v});
    chk({nm, "/valid8"}, {255'h0, vo8}, {255'h0, v});
    if (v) begin
      e = q4.pop_front(); chk({nm, "/data4"}, {128'h0, nv4}, e); last4 = e;
      e = q1.pop_front(); chk({nm, "/data1"}, {224'h0, nv1}, e); last1 = e;
      e = q8.pop_front(); chk({nm, "/data8"}, nv8, e);           last8 = e;
    end else begin
      chk({nm, "/hold4"}, {128'h0, nv4}, last4);
      chk({nm, "/hold1"}, {224'h0, nv1}, last1);
      chk({nm, "/hold8"}, nv8, last8);
    end
  endtask

  typedef struct {
    logic [127:0] vin;
    logic [127:0] vexp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [127:0] x, y, e;
    logic         iv;

    // lane 0 in bits [31:0]
    tbl[0].vin  = {32'h7563C5C0, 32'h76757CC5, 32'h7B76D27C, 32'h637BC0D2};
    tbl[0].vexp = {32'h4A27DCA2, 32'hCADDAF02, 32'hC28636D1, 32'h591CEEA1};
    tbl[1].vin  = {96'h0, 32'hDB135345};
    tbl[1].vexp = {96'h0, 32'h8E4DA1BC};
    tbl[2].vin  = {64'h0, 32'hF20A225C, 32'h0};
    tbl[2].vexp = {64'h0, 32'h9FDC589D, 32'h0};
    tbl[3].vin  = {32'h0, 32'h01010101, 64'h0};
    tbl[3].vexp = {32'h0, 32'h01010101, 64'h0};
    tbl[4].vin  = {32'hC6C6C6C6, 96'h0};
    tbl[4].vexp = {32'hC6C6C6C6, 96'h0};

    rst = 1'b1; valid_in = 1'b0; inv = 1'b0;
    vect4 = '0; vect1 = '0; vect8 = '0;
    last4 = '0; last1 = '0; last8 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset/data4", {128'h0, nv4}, 256'h0);
    chk("reset/valid4", {255'h0, vo4}, 256'h0);
    chk("reset/data8", nv8, 256'h0);
    rst = 1'b0;

    // Table-driven forward vectors
    for (int t = 0; t < 5; t++) cycle(1'b1, 1'b0, tbl[t].vin, tbl[t].vexp, "table");

    // Hold for three idle cycles
    for (int t = 0; t < 3; t++) cycle(1'b0, 1'b0, '0, '0, "hold");

    // Inverse (or ignored inv in the forward-only build)
    x = {96'h0, 32'h591CEEA1};
`ifdef INV_MIX_COLUMNS_EN
    e = {96'h0, 32'h637BC0D2};
`else
    e = {96'h0, 32'hCD60_B1A7} ^ {96'h0, 32'hCD60_B1A7} ^ mc4(x, 1'b0);
`endif
    cycle(1'b1, 1'b1, x, e, "inv_col");
    x = {96'h0, 32'h637BC0D2};
`ifdef INV_MIX_COLUMNS_EN
    e = mc4(x, 1'b1);
`else
    e = {96'h0, 32'h591CEEA1};
`endif
    cycle(1'b1, 1'b1, x, e, "inv_ignored");

    // Back-to-back forward then inverse of the result
    x = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hA5A55A5A};
    y = mc4(x, 1'b0);
    cycle(1'b1, 1'b0, x, y, "b2b_fwd");
`ifdef INV_MIX_COLUMNS_EN
    e = x;
`else
    e = mc4(y, 1'b0);
`endif
    cycle(1'b1, 1'b1, y, e, "b2b_inv");

    // Reset mid-stream, asserted between clock edges
    valid_in = 1'b1; inv = 1'b0; vect4 = tbl[1].vin;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst/data4", {128'h0, nv4}, 256'h0);
    chk("midrst/valid4", {255'h0, vo4}, 256'h0);
    chk("midrst/data1", {224'h0, nv1}, 256'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_edge/valid4", {255'h0, vo4}, 256'h0);
    chk("rst_edge/data4", {128'h0, nv4}, 256'h0);
    valid_in = 1'b0;
    rst = 1'b0;
    q4.delete(); q1.delete(); q8.delete();
    last4 = '0; last1 = '0; last8 = '0;
    cycle(1'b0, 1'b0, tbl[0].vin, '0, "post_rst_idle");
    cycle(1'b0, 1'b0, tbl[0].vin, '0, "post_rst_idle");
    cycle(1'b1, 1'b0, tbl[0].vin, tbl[0].vexp, "post_rst_first");

    // Random vectors on all three lane counts, valid every cycle
    for (int n = 0; n < 1000; n++) begin
      for (int l = 0; l < 4; l++) x[32*l +: 32] = $urandom;
      iv = 1'($urandom_range(0, 1));
      cycle(1'b1, iv, x, mc4(x, iv), "rand");
    end

    // Random vectors with gaps in valid_in
    for (int n = 0; n < 200; n++) begin
      for (int l = 0; l < 4; l++) x[32*l +: 32] = $urandom;
      iv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) cycle(1'b1, iv, x, mc4(x, iv), "rand_gap");
      else                           cycle(1'b0, iv, x, '0, "rand_gap");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_aes_mix_columns

// File: doc/aes_mix_columns.md
# aes_mix_columns

Registered AES MixColumns stage for the SIMD vector datapath. It applies the AES MixColumns matrix over GF(2^8) independently to every 32-bit lane of a vector operand, where each lane holds one state column. The result is registered and has one-cycle latency. It sits in the vector execute unit next to the SubBytes, ShiftRows and AddRoundKey units.

## Interface
Parameters:
- regSize, 32: lane width in bits. Must be 32; any other value is an elaboration error.
- vecSize, 4: number of lanes. Must be at least 1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  qualifies vect for capture.
- inv  in  1  1 selects InvMixColumns. Only honoured when INV_MIX_COLUMNS_EN is defined.
- vect  in  [vecSize-1:0][regSize-1:0]  input columns. Lane i is column i.
- new_vect  out  [vecSize-1:0][regSize-1:0]  transformed columns, registered.
- valid_out  out  1  new_vect holds a fresh result this cycle.

## Operation
- Lane byte mapping: s0 = bits[31:24], s1 = [23:16], s2 = [15:8], s3 = [7:0]. Output bytes use the same positions.
- Forward transform, per lane:
  - r0 = 2·s0 ^ 3·s1 ^ s2 ^ s3
  - r1 = s0 ^ 2·s1 ^ 3·s2 ^ s3
  - r2 = s0 ^ s1 ^ 2·s2 ^ 3·s3
  - r3 = 3·s0 ^ s1 ^ s2 ^ 2·s3
- Multiplication:
  - 2·x = xtime(x) = (x<<1)[7:0] ^ (x[7] ? 8'h1B : 8'h00).
  - 3·x = xtime(x) ^ x.
  - All arithmetic is 8-bit XOR. No carries.
- Inverse transform (macro only): matrix rows {0E,0B,0D,09}, {09,0E,0B,0D}, {0D,09,0E,0B}, {0B,0D,09,0E}. Each product is built from repeated xtime.
- Lanes are fully independent. No byte crosses a lane boundary.

## Timing
- Reset: new_vect = 0 and valid_out = 0, applied immediately on rst assertion, independent of clk.
- Rising clk edge with valid_in = 1: new_vect <= transform(vect, inv) and valid_out <= 1.
- Rising clk edge with valid_in = 0: new_vect holds its previous value and valid_out <= 0.
- Latency is exactly 1 cycle. Throughput is one vector per cycle. There is no backpressure and no stall input.
- The combinational path from vect/inv to the register is a single transform. It has no internal pipelining.
- Reset asserted mid-stream: an in-flight result is discarded. After release, the first valid_in edge produces valid output on the next cycle.
- rst and a clk edge together: reset wins.

## Configuration
- INV_MIX_COLUMNS_EN defined: inv = 1 selects InvMixColumns. inv is sampled with valid_in and may change every cycle.
- Not defined: the inverse logic is not built, inv is ignored, and the forward transform is always applied. The port list is identical in both builds.

## Structure
- Package aes_pkg holds:
  - function xtime (8-bit → 8-bit) and the reduction constant 8'h1B.
  - gf_mul helpers for the constants 2, 3, 9, B, D, E.
  - typedef byte_t = logic [7:0].
- Sub-module mix_single_column: combinational, a 32-bit column plus inv in, a 32-bit column out. It is instantiated vecSize times in a generate loop. The top level contains only the registers and valid logic.

## Test plan
- Forward transform, valid_in = 1, inv = 0, vect = {637BC0D2, 7B76D27C, 76757CC5, 7563C5C0} for lanes 0..3. One cycle later new_vect = {591CEEA1, C28636D1, CADDAF02, 4A27DCA2} and valid_out = 1.
- Standard column vectors in one lane each:
  - DB135345 → 8E4DA1BC
  - F20A225C → 9FDC589D
  - 01010101 → 01010101
  - C6C6C6C6 → C6C6C6C6
- Reset: assert rst mid-stream without a clock edge. new_vect = 0 and valid_out = 0 immediately. After release with valid_in = 0, both stay 0.
- Hold: valid_in = 0 for 3 cycles after a result. new_vect stays constant and valid_out = 0.
- Inverse, INV_MIX_COLUMNS_EN builds only: inv = 1, lane = 591CEEA1 → 637BC0D2. Back-to-back forward then inverse of the same value returns the original. Without the macro, inv = 1 still yields 591CEEA1 for input 637BC0D2.
- vecSize = 1 and vecSize = 8 elaborations: every lane matches the per-column reference model for 1000 random vectors.
